// File: rtl/priority_bit_iterator.sv
// Splits an accepted DATA_W-bit word into one output beat per set bit (LSB- or MSB-first).
// Optional build macro PRIO_ITER_POPCNT_EN adds popcnt_o and beat_idx_o.
module priority_bit_iterator #(
    parameter int DATA_W = 16,
    localparam int IDX_W = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              srst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              msb_first_i,
    input  logic              data_val_i,
    output logic              data_ready_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic [DATA_W-1:0] onehot_o,
    output logic              none_o,
    output logic              last_o,
    output logic              out_val_o,
    input  logic              out_ready_i
`ifdef PRIO_ITER_POPCNT_EN
    ,
    output logic [IDX_W:0]    popcnt_o,
    output logic [IDX_W-1:0]  beat_idx_o
`endif
);

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_e;

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   resid_q, resid_d;
    logic                mode_q, mode_d;
    logic                out_val_q, out_val_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   onehot_q, onehot_d;
    logic                none_q, none_d;
    logic                last_q, last_d;

    logic                fire;
    logic                accept;
    logic                load;
    logic [DATA_W-1:0]   src_word;
    logic                src_msb;
    logic [IDX_W-1:0]    sel_idx;
    logic [DATA_W-1:0]   sel_onehot;

`ifdef PRIO_ITER_POPCNT_EN
    logic [IDX_W:0]      popcnt_q, popcnt_d;
    logic [IDX_W-1:0]    beat_idx_q, beat_idx_d;

    function automatic logic [IDX_W:0] count_ones(input logic [DATA_W-1:0] w);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) c = c + {{IDX_W{1'b0}}, w[i]};
        return c;
    endfunction
`endif

    // Later matches overwrite earlier ones, so the scan direction picks lowest or highest bit.
    function automatic logic [IDX_W-1:0] pick_bit(input logic [DATA_W-1:0] w, input logic msb);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (msb) begin
                if (w[i]) r = IDX_W'(i);
            end else begin
                if (w[DATA_W-1-i]) r = IDX_W'(DATA_W - 1 - i);
            end
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can infer a latch.
        state_d   = state_q;
        resid_d   = resid_q;
        mode_d    = mode_q;
        out_val_d = out_val_q;
        idx_d     = idx_q;
        onehot_d  = onehot_q;
        none_d    = none_q;
        last_d    = last_q;
        src_word  = resid_q;
        src_msb   = mode_q;
        load      = 1'b0;
`ifdef PRIO_ITER_POPCNT_EN
        popcnt_d   = popcnt_q;
        beat_idx_d = beat_idx_q;
`endif

        fire         = out_val_q && out_ready_i;
        data_ready_o = (state_q == ST_IDLE) || (fire && last_q);
        accept       = data_val_i && data_ready_o;

        if (accept) begin
            src_word = data_i;
            src_msb  = msb_first_i;
            load     = 1'b1;
            mode_d   = msb_first_i;
            state_d  = ST_EMIT;
            none_d   = (data_i == '0);
`ifdef PRIO_ITER_POPCNT_EN
            popcnt_d   = count_ones(data_i);
            beat_idx_d = '0;
`endif
        end else if (fire) begin
            if (last_q) begin
                state_d   = ST_IDLE;
                out_val_d = 1'b0;
                idx_d     = '0;
                onehot_d  = '0;
                none_d    = 1'b0;
                last_d    = 1'b0;
`ifdef PRIO_ITER_POPCNT_EN
                popcnt_d   = '0;
                beat_idx_d = '0;
`endif
            end else begin
                load = 1'b1;
`ifdef PRIO_ITER_POPCNT_EN
                beat_idx_d = beat_idx_q + 1'b1;
`endif
            end
        end

        // The beat is precomputed here so the outputs come straight from flops; resid holds only bits not yet shown.
        sel_idx    = pick_bit(src_word, src_msb);
        sel_onehot = (src_word == '0) ? '0 : (ONE << sel_idx);

        if (load) begin
            out_val_d = 1'b1;
            idx_d     = sel_idx;
            onehot_d  = sel_onehot;
            resid_d   = src_word & ~sel_onehot;
            last_d    = ((src_word & ~sel_onehot) == '0);
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q   <= ST_IDLE;
            resid_q   <= '0;
            mode_q    <= 1'b0;
            out_val_q <= 1'b0;
            idx_q     <= '0;
            onehot_q  <= '0;
            none_q    <= 1'b0;
            last_q    <= 1'b0;
`ifdef PRIO_ITER_POPCNT_EN
            popcnt_q   <= '0;
            beat_idx_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            resid_q   <= resid_d;
            mode_q    <= mode_d;
            out_val_q <= out_val_d;
            idx_q     <= idx_d;
            onehot_q  <= onehot_d;
            none_q    <= none_d;
            last_q    <= last_d;
`ifdef PRIO_ITER_POPCNT_EN
            popcnt_q   <= popcnt_d;
            beat_idx_q <= beat_idx_d;
`endif
        end
    end

    assign out_val_o = out_val_q;
    assign idx_o     = idx_q;
    assign onehot_o  = onehot_q;
    assign none_o    = none_q;
    assign last_o    = last_q;
`ifdef PRIO_ITER_POPCNT_EN
    assign popcnt_o   = popcnt_q;
    assign beat_idx_o = beat_idx_q;
`endif

endmodule
